// File: rtl/serving_pkg.sv
// serving_pkg: shared FSM encoding and word geometry for the serving RAM bridge
package serving_pkg;
  localparam int BYTES_PER_WORD = 4;
  typedef enum logic [2:0] {IDLE, WRITE, READ, RDLAST, ACK} state_t;
endpackage

// File: rtl/serving_ram_bridge_if.sv
// serving_ram_bridge_if: byte-wide RAM port between the bridge and serving_ram
interface serving_ram_bridge_if #(
  parameter int aw = 8
) ();
  logic [aw-1:0] waddr;
  logic [7:0]    wdata;
  logic          wen;
  logic [aw-1:0] raddr;
  logic          ren;
  logic [7:0]    rdata;
  modport master (output waddr, wdata, wen, raddr, ren, input rdata);
  modport slave  (input waddr, wdata, wen, raddr, ren, output rdata);
endinterface

// File: rtl/serving_ram.sv
// serving_ram: byte-wide RAM with registered read data and no preload
module serving_ram #(
  parameter int depth = 256
) (
  input logic                 i_clk,
  serving_ram_bridge_if.slave bus
);
  logic [7:0] mem [depth];
  always_ff @(posedge i_clk) begin
    if (bus.wen) mem[bus.waddr] <= bus.wdata;
    if (bus.ren) bus.rdata <= mem[bus.raddr];
  end
endmodule

// File: rtl/serving_ram_bridge.sv
// serving_ram_bridge: 32-bit Wishbone slave serialised onto an 8-bit registered RAM port
module serving_ram_bridge
  import serving_pkg::*;
#(
  parameter int depth = 256,
  parameter int aw    = $clog2(depth)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [aw-1:0] i_wb_adr,
  input  logic [31:0]   i_wb_dat,
  input  logic [3:0]    i_wb_sel,
  input  logic          i_wb_we,
  input  logic          i_wb_stb,
  output logic [31:0]   o_wb_rdt,
  output logic          o_wb_ack,
  output logic [aw-1:0] o_waddr,
  output logic [7:0]    o_wdata,
  output logic          o_wen,
  output logic [aw-1:0] o_raddr,
  output logic          o_ren,
  input  logic [7:0]    i_rdata
);
  localparam int cw = $clog2(BYTES_PER_WORD);
  state_t        state;
  logic [cw-1:0] cnt;
  logic [cw-1:0] nxt;
  logic [cw-1:0] prv;
  logic          last;
  logic [aw-3:0] adr;
  logic [31:0]   dat;
  logic [3:0]    sel;
  logic          unused;
  assign nxt    = cnt + 1'b1;
  assign prv    = cnt - 1'b1;
  assign last   = &cnt;
  assign unused = &{1'b0, i_wb_adr[1:0]};
  // RAM-side outputs are registered one step ahead so they line up with the state they belong to
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      adr      <= '0;
      dat      <= '0;
      sel      <= '0;
      o_wb_rdt <= '0;
      o_wb_ack <= 1'b0;
      o_waddr  <= '0;
      o_wdata  <= '0;
      o_wen    <= 1'b0;
      o_raddr  <= '0;
      o_ren    <= 1'b0;
    end else begin
      o_wb_ack <= 1'b0;
      o_wen    <= 1'b0;
      o_ren    <= 1'b0;
      case (state)
        IDLE: if (i_wb_stb) begin
          adr     <= i_wb_adr[aw-1:2];
          dat     <= i_wb_dat;
          sel     <= i_wb_sel;
          cnt     <= '0;
          state   <= i_wb_we ? WRITE : READ;
          o_waddr <= {i_wb_adr[aw-1:2], 2'b00};
          o_raddr <= {i_wb_adr[aw-1:2], 2'b00};
          o_wdata <= i_wb_dat[7:0];
          o_wen   <= i_wb_we & i_wb_sel[0];
          o_ren   <= !i_wb_we;
        end
        WRITE: begin
          cnt      <= nxt;
          state    <= last ? ACK : WRITE;
          o_wb_ack <= last;
          o_waddr  <= {adr, nxt};
          o_wdata  <= dat[{nxt, 3'b000} +: 8];
          o_wen    <= !last & sel[nxt];
        end
        READ: begin
          if (cnt != '0) o_wb_rdt[{prv, 3'b000} +: 8] <= i_rdata;
          cnt     <= nxt;
          state   <= last ? RDLAST : READ;
          o_raddr <= {adr, nxt};
          o_ren   <= !last;
        end
        RDLAST: begin
          o_wb_rdt[31:24] <= i_rdata;
          o_wb_ack        <= 1'b1;
          state           <= ACK;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serving_ram_bridge.sv
// tb_serving_ram_bridge: scoreboard bench for the bridge paired with serving_ram
module tb_serving_ram_bridge;
  typedef struct {int cyc; logic [31:0] rdt;} ack_t;
  typedef struct {int cyc; logic [7:0] a; logic [7:0] d;} wr_t;
  typedef struct {int cyc; logic [7:0] a;} rd_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  adr = '0;
  logic [31:0] dat = '0;
  logic [3:0]  sel = '0;
  logic        we  = 1'b0;
  logic        stb = 1'b0;
  logic [31:0] rdt;
  logic        ack;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  ack_t        ackq[$];
  wr_t         wq[$];
  rd_t         rq[$];

  serving_ram_bridge_if #(.aw(8)) bus ();

  serving_ram_bridge #(.depth(256)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel), .i_wb_we(we), .i_wb_stb(stb),
    .o_wb_rdt(rdt), .o_wb_ack(ack),
    .o_waddr(bus.waddr), .o_wdata(bus.wdata), .o_wen(bus.wen),
    .o_raddr(bus.raddr), .o_ren(bus.ren), .i_rdata(bus.rdata)
  );

  serving_ram #(.depth(256)) ram (.i_clk(clk), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  // Every ack and every RAM strobe must match the next queued expectation, cycle included
  always @(negedge clk) begin
    if (ack === 1'b1) begin : mon_ack
      ack_t e;
      checks++;
      if (ackq.size() == 0) begin
        errors++;
        $display("FAIL ack: unexpected ack at cycle %0d rdt %h", cyc, rdt);
      end else begin
        e = ackq.pop_front();
        if (e.cyc != cyc || rdt !== e.rdt) begin
          errors++;
          $display("FAIL ack: got cycle %0d rdt %h want cycle %0d rdt %h", cyc, rdt, e.cyc, e.rdt);
        end
      end
    end
    if (bus.wen === 1'b1) begin : mon_wr
      wr_t e;
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL wen: unexpected write at cycle %0d addr %h data %h", cyc, bus.waddr, bus.wdata);
      end else begin
        e = wq.pop_front();
        if (e.cyc != cyc || bus.waddr !== e.a || bus.wdata !== e.d) begin
          errors++;
          $display("FAIL wen: got cycle %0d addr %h data %h want cycle %0d addr %h data %h",
                   cyc, bus.waddr, bus.wdata, e.cyc, e.a, e.d);
        end
      end
    end
    if (bus.ren === 1'b1) begin : mon_rd
      rd_t e;
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL ren: unexpected read at cycle %0d addr %h", cyc, bus.raddr);
      end else begin
        e = rq.pop_front();
        if (e.cyc != cyc || bus.raddr !== e.a) begin
          errors++;
          $display("FAIL ren: got cycle %0d addr %h want cycle %0d addr %h", cyc, bus.raddr, e.cyc, e.a);
        end
      end
    end
  end

  task automatic check_reset();
    check("rst_ack", ack, 0);
    check("rst_wen", bus.wen, 0);
    check("rst_ren", bus.ren, 0);
    check("rst_rdt", rdt, 0);
    check("rst_waddr", bus.waddr, 0);
    check("rst_raddr", bus.raddr, 0);
    check("rst_wdata", bus.wdata, 0);
  endtask

  task automatic wait_acks(input int n);
    int got = 0;
    int t = 0;
    while (got < n && t < 20 * n) begin
      @(negedge clk);
      t++;
      if (ack === 1'b1) got++;
    end
    check("ack_count", got, n);
  endtask

  // Called at the negedge of an IDLE cycle; n > 1 keeps stb high for back-to-back transfers
  task automatic xfer(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic w, input int n, input logic [31:0] exp_rdt);
    int c = cyc;
    adr = a; dat = d; sel = s; we = w; stb = 1'b1;
    for (int i = 0; i < n; i++) begin
      int b = c + i * (w ? 6 : 7);
      for (int k = 0; k < 4; k++) begin
        logic [7:0] ba = {a[7:2], k[1:0]};
        if (w && s[k]) wq.push_back('{b + 1 + k, ba, d[8*k +: 8]});
        if (!w) rq.push_back('{b + 1 + k, ba});
      end
      ackq.push_back('{b + (w ? 5 : 6), exp_rdt});
    end
    wait_acks(n);
    stb = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int c;
    repeat (3) @(negedge clk);
    check_reset();
    rst = 1'b0;
    @(negedge clk);
    xfer(8'h10, 32'hDEADBEEF, 4'hF, 1'b1, 1, 32'h0);
    xfer(8'h10, 32'h0,        4'h0, 1'b0, 1, 32'hDEADBEEF);
    xfer(8'h10, 32'h11223344, 4'h5, 1'b1, 1, 32'hDEADBEEF);
    xfer(8'h10, 32'h0,        4'h0, 1'b0, 1, 32'hDE22BE44);
    xfer(8'h14, 32'hCAFEF00D, 4'h0, 1'b1, 1, 32'hDE22BE44);
    xfer(8'h20, 32'h00000000, 4'hF, 1'b1, 1, 32'hDE22BE44);
    c = cyc;
    adr = 8'h20; dat = 32'h55667788; sel = 4'hF; we = 1'b1; stb = 1'b1;
    wq.push_back('{c + 1, 8'h20, 8'h88});
    wq.push_back('{c + 2, 8'h21, 8'h77});
    repeat (2) @(negedge clk);
    rst = 1'b1;
    stb = 1'b0;
    @(negedge clk);
    check_reset();
    rst = 1'b0;
    @(negedge clk);
    xfer(8'h20, 32'h0,        4'h0, 1'b0, 1, 32'h00007788);
    xfer(8'hFC, 32'hA1B2C3D4, 4'hF, 1'b1, 1, 32'h00007788);
    xfer(8'hFC, 32'h0,        4'h0, 1'b0, 2, 32'hA1B2C3D4);
    repeat (10) @(negedge clk);
    check("ackq_left", ackq.size(), 0);
    check("wq_left", wq.size(), 0);
    check("rq_left", rq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/serving_ram_bridge.md
SERVING_RAM_BRIDGE -- requirements
Module: serving_ram_bridge

Interface
REQ-001 SHALL have parameter depth, default 256: RAM size in bytes.
REQ-002 SHALL have parameter aw, default $clog2(depth): byte address width; aw >= 3.
REQ-003 SHALL have port i_clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port i_rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_wb_adr  input  aw  Wishbone byte address; bits [1:0] ignored.
REQ-006 SHALL have port i_wb_dat  input  32  write data.
REQ-007 SHALL have port i_wb_sel  input  4  byte enables, bit k = byte k (little-endian).
REQ-008 SHALL have port i_wb_we  input  1  1 = write, 0 = read.
REQ-009 SHALL have port i_wb_stb  input  1  request valid (cyc folded in).
REQ-010 SHALL have port o_wb_rdt  output  32  read data, valid when o_wb_ack = 1.
REQ-011 SHALL have port o_wb_ack  output  1  single-cycle completion strobe.
REQ-012 SHALL have port o_waddr  output  aw  RAM byte write address.
REQ-013 SHALL have port o_wdata  output  8  RAM write byte.
REQ-014 SHALL have port o_wen  output  1  RAM write enable.
REQ-015 SHALL have port o_raddr  output  aw  RAM byte read address.
REQ-016 SHALL have port o_ren  output  1  RAM read strobe.
REQ-017 SHALL have port i_rdata  input  8  RAM read byte, registered: valid the cycle after o_raddr is presented with o_wen = 0.

Function
REQ-018 SHALL implement FSM states IDLE, WRITE, READ, RDLAST, ACK.
REQ-019 In IDLE with i_wb_stb = 1, SHALL latch adr[aw-1:2], dat, sel and we, clear byte counter cnt (2 bits), and go to WRITE if we = 1, else READ.
REQ-020 In WRITE, each cycle SHALL drive o_waddr = {adr, cnt}, o_wdata = dat byte cnt and o_wen = sel[cnt]; then increment cnt; leave for ACK when cnt = 3.
REQ-021 In READ, each cycle SHALL drive o_ren = 1, o_raddr = {adr, cnt} and o_wen = 0; when cnt > 0, capture i_rdata into rdt byte cnt-1; leave for RDLAST when cnt = 3.
REQ-022 In RDLAST, SHALL capture i_rdata into rdt byte 3 and go to ACK.
REQ-023 In ACK, SHALL assert o_wb_ack for exactly one cycle and return to IDLE.
REQ-024 Latency, counted from the IDLE cycle that samples stb: write ack in cycle 5, read ack in cycle 6.
REQ-025 If stb stays high through ACK, a new transaction SHALL start in the IDLE cycle that follows; stb is never sampled outside IDLE.
REQ-026 o_wen and o_ren SHALL be 0 in IDLE, ACK and RDLAST; o_wen SHALL be 0 in READ/RDLAST and o_ren SHALL be 0 in WRITE.
REQ-027 sel = 0000 on a write SHALL still take 4 cycles and ack, with no o_wen pulse.
REQ-028 Byte addresses SHALL wrap only within the word; top word {all ones, 00..11} SHALL NOT overflow.
REQ-029 o_wb_rdt SHALL hold its last read value until the next read's bytes are captured; writes SHALL NOT alter it.

Reset
REQ-030 With i_rst = 1 at a clock edge: state = IDLE, cnt = 0, o_wb_ack = 0, o_wen = 0, o_ren = 0, o_wb_rdt = 0, address/data outputs = 0.
REQ-031 Reset mid-transaction SHALL abort it: no ack, no further o_wen, and bytes already written stay written.

Structure
REQ-032 FSM state encoding and the BYTES_PER_WORD = 4 constant SHALL live in shared package serving_pkg.
REQ-033 SHALL contain no sub-module; the bench SHALL pair it with a serving_ram instance (depth 256, preload disabled).

Verification
REQ-034 Write adr 0x10, dat 0xDEADBEEF, sel 1111 -> o_wen pulses in cycles 1-4 at 0x10..0x13 with EF, BE, AD, DE; ack in cycle 5.
REQ-035 Read adr 0x10 after REQ-034 -> o_ren high in cycles 1-4; o_wb_rdt = 0xDEADBEEF with ack in cycle 6.
REQ-036 Write 0x11223344 to 0x10 with sel 0101, then read -> o_wen only at 0x10 and 0x12; readback 0xDE22BE44.
REQ-037 Assert i_rst during the third WRITE cycle of a sel 1111 write to 0x20 -> only 0x20 and 0x21 written, no ack, IDLE next cycle.
REQ-038 Hold stb high across two reads of 0xFC -> addresses 0xFC..0xFF, acks 7 cycles apart, o_wb_ack never high two cycles in a row.
